aes_encrypt: RTL and testbench

Iterative AES block-cipher encryption core (FIPS-197), parameterised for AES-128/192/256 through `nk`/`nr`. It computes one round per clock and holds the ciphertext until the next start. It sits between the top-level stimulus/key source and the display encoder / decipher stage, which consumes `out` once `done` is high.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_encrypt_if.sv | 14 +
 rtl/aes_round.sv | 26 ++
 rtl/aes_encrypt.sv | 115 +++++++++++
 tb/tb_aes_encrypt.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, Rcon, GF(2^8) helpers, key-size constants and FSM states.
package aes_pkg;

  localparam int NK_128 = 4;
  localparam int NR_128 = 10;
  localparam int NK_192 = 6;
  localparam int NR_192 = 12;
  localparam int NK_256 = 8;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Element 0 is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Index 0 is unused; key expansion starts at Rcon[1].
  localparam logic [0:10][7:0] RCON = {
    8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// Request/result bundle between the stimulus/key source (master) and the cipher core (slave).
interface aes_encrypt_if #(
  parameter int nk = 4
);
  logic             start;
  logic [nk*32-1:0] key;
  logic [127:0]     in;
  logic [127:0]     out;
  logic             busy;
  logic             done;

  modport master (output start, key, in, input out, busy, done);
  modport slave  (input start, key, in, output out, busy, done);
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);
  logic [127:0] sr;
  logic [127:0] mc;

  // Byte k lives at column k/4, row k%4; row r rotates left by r columns.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = ((C + R) % 4) * 4 + R;
    assign sr[127-8*gi -: 8] = sbox(state_i[127-8*SRC -: 8]);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign mc[127-32*gi -: 32] = mix_column(sr[127-32*gi -: 32]);
  end

  assign state_o = (last_i ? sr : mc) ^ rk_i;
endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
// Optional ENCRYPT_PARAM_CHECK_EN rejects illegal (nk,nr) pairs at elaboration.
module aes_encrypt
  import aes_pkg::*;
#(
  parameter int nk = NK_128,
  parameter int nr = NR_128
) (
  input  logic         clk,
  input  logic         reset,
  aes_encrypt_if.slave bus
);
  localparam int         NW   = 4 * (nr + 1);
  localparam logic [3:0] NR_L = 4'(nr);

`ifdef ENCRYPT_PARAM_CHECK_EN
  if (!((nk == NK_128 && nr == NR_128) || (nk == NK_192 && nr == NR_192) ||
        (nk == NK_256 && nr == NR_256))) begin : g_param_check
    $fatal(1, "aes_encrypt: illegal (nk,nr) = (%0d,%0d)", nk, nr);
  end
`else
`endif

  aes_state_e       st_q, st_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [127:0]     state_q, state_d;
  logic [127:0]     out_q, out_d;
  logic [nk*32-1:0] key_q, key_d;
  logic [31:0]      w_all [NW];
  logic [127:0]     rk_all [16];
  logic [127:0]     round_out;
  logic             last;

  // Key expansion over the latched key; each word is its own net so the chain stays acyclic.
  for (genvar gi = 0; gi < NW; gi++) begin : g_w
    logic [31:0] word;
    if (gi < nk) begin : g_key
      assign word = key_q[nk*32-1-32*gi -: 32];
    end else if (gi % nk == 0) begin : g_rcon
      assign word = g_w[gi-nk].word ^ sub_word(rot_word(g_w[gi-1].word)) ^ {RCON[gi/nk], 24'h0};
    end else if (nk > 6 && gi % nk == 4) begin : g_sub
      assign word = g_w[gi-nk].word ^ sub_word(g_w[gi-1].word);
    end else begin : g_xor
      assign word = g_w[gi-nk].word ^ g_w[gi-1].word;
    end
    assign w_all[gi] = word;
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_rk
    if (gi <= nr) begin : g_used
      assign rk_all[gi] = {w_all[4*gi], w_all[4*gi+1], w_all[4*gi+2], w_all[4*gi+3]};
    end else begin : g_unused
      assign rk_all[gi] = '0;
    end
  end

  assign last = (rnd_q == NR_L);

  aes_round u_round (
    .state_i (state_q),
    .rk_i    (rk_all[rnd_q]),
    .last_i  (last),
    .state_o (round_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      out_q   <= '0;
      key_q   <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      out_q   <= out_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    out_d   = out_q;
    key_d   = key_q;
    case (st_q)
      RUN: begin
        state_d = round_out;
        if (last) begin
          out_d = round_out;
          st_d  = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        // Round key 0 is the first four key words, taken straight from the input.
        if (bus.start) begin
          key_d   = bus.key;
          state_d = bus.in ^ bus.key[nk*32-1 -: 128];
          rnd_d   = 4'd1;
          st_d    = RUN;
        end
      end
    endcase
  end

  always_comb begin
    bus.out  = out_q;
    bus.busy = (st_q == RUN);
    bus.done = (st_q == DONE);
  end
endmodule

// File: tb/tb_aes_encrypt.sv
// Directed known-answer bench for aes_encrypt at all three key sizes.
module tb_aes_encrypt;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KB     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_encrypt_if #(.nk(NK_128)) if128 ();
  aes_encrypt_if #(.nk(NK_192)) if192 ();
  aes_encrypt_if #(.nk(NK_256)) if256 ();

  aes_encrypt #(.nk(NK_128), .nr(NR_128)) dut128 (.clk(clk), .reset(reset), .bus(if128));
  aes_encrypt #(.nk(NK_192), .nr(NR_192)) dut192 (.clk(clk), .reset(reset), .bus(if192));
  aes_encrypt #(.nk(NK_256), .nr(NR_256)) dut256 (.clk(clk), .reset(reset), .bus(if256));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    if128.start = 1'b0; if128.key = '0; if128.in = '0;
    if192.start = 1'b0; if192.key = '0; if192.in = '0;
    if256.start = 1'b0; if256.key = '0; if256.in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out128", if128.out, '0);
    check_bit("rst_done128", if128.done, 1'b0);
    check_bit("rst_busy128", if128.busy, 1'b0);
    check_bit("rst_busy256", if256.busy, 1'b0);

    // AES-128 known answer; edge 0 is the posedge right after start is raised
    if128.key = K128; if128.in = PT; if128.start = 1'b1;
    @(negedge clk); if128.start = 1'b0;
    check_bit("a128_busy_e0", if128.busy, 1'b1);
    check_bit("a128_done_e0", if128.done, 1'b0);
    repeat (9) @(negedge clk);
    check_bit("a128_done_e9", if128.done, 1'b0);
    check("a128_out_e9", if128.out, '0);
    @(negedge clk);
    check_bit("a128_done_e10", if128.done, 1'b1);
    check_bit("a128_busy_e10", if128.busy, 1'b0);
    check("a128_out_e10", if128.out, CT128);
    @(negedge clk);
    check("a128_out_hold", if128.out, CT128);
    check_bit("a128_done_hold", if128.done, 1'b1);

    // Restart from DONE, then disturb inputs and pulse start mid-run
    if128.start = 1'b1;
    @(negedge clk); if128.start = 1'b0; if128.in = '0; if128.key = '0;
    check_bit("mid_done_cleared", if128.done, 1'b0);
    check("mid_out_held", if128.out, CT128);
    repeat (3) @(negedge clk);
    if128.start = 1'b1;
    @(negedge clk); if128.start = 1'b0;
    check_bit("mid_busy_e4", if128.busy, 1'b1);
    repeat (5) @(negedge clk);
    check_bit("mid_done_e9", if128.done, 1'b0);
    @(negedge clk);
    check_bit("mid_done_e10", if128.done, 1'b1);
    check("mid_out_e10", if128.out, CT128);

    // Start held high: ignored through RUN, accepted again one edge after DONE
    if128.key = KB; if128.in = PTB; if128.start = 1'b1;
    repeat (11) @(negedge clk);
    check_bit("b2b_done_e10", if128.done, 1'b1);
    check("b2b_out_e10", if128.out, CTB);
    @(negedge clk); if128.start = 1'b0;
    check_bit("b2b_done_e11", if128.done, 1'b0);
    check_bit("b2b_busy_e11", if128.busy, 1'b1);
    repeat (10) @(negedge clk);
    check_bit("b2b_done_e21", if128.done, 1'b1);
    check("b2b_out_e21", if128.out, CTB);

    // AES-192 known answer
    if192.key = K192; if192.in = PT; if192.start = 1'b1;
    @(negedge clk); if192.start = 1'b0;
    repeat (11) @(negedge clk);
    check_bit("a192_done_e11", if192.done, 1'b0);
    @(negedge clk);
    check_bit("a192_done_e12", if192.done, 1'b1);
    check("a192_out_e12", if192.out, CT192);

    // AES-256 known answer
    if256.key = K256; if256.in = PT; if256.start = 1'b1;
    @(negedge clk); if256.start = 1'b0;
    repeat (13) @(negedge clk);
    check_bit("a256_done_e13", if256.done, 1'b0);
    @(negedge clk);
    check_bit("a256_done_e14", if256.done, 1'b1);
    check("a256_out_e14", if256.out, CT256);

    // Asynchronous reset in the middle of an AES-256 run
    if256.start = 1'b1;
    @(negedge clk); if256.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_out", if256.out, '0);
    check_bit("rst_mid_done", if256.done, 1'b0);
    check_bit("rst_mid_busy", if256.busy, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    if256.start = 1'b1;
    @(negedge clk); if256.start = 1'b0;
    repeat (13) @(negedge clk);
    check_bit("rerun_done_e13", if256.done, 1'b0);
    @(negedge clk);
    check_bit("rerun_done_e14", if256.done, 1'b1);
    check("rerun_out_e14", if256.out, CT256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
